regfile_wr_ctrl: RTL and testbench
==================================

REGFILE_WR_CTRL -- requirements
Module: regfile_wr_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 4, register-file address width.
REQ-002 The block SHALL have parameter DW, default 8, register-file data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, >=2).
REQ-004 The block SHALL have parameter CLR_VAL, default 8'h00, value written to every entry during a clear sweep.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cmd_valid  input  1  upstream write command present.
REQ-008 cmd_addr  input  AW  command target address.
REQ-009 cmd_data  input  DW  command write data.
REQ-010 cmd_ready  output  1  FIFO can accept; a transfer occurs on an edge where cmd_valid && cmd_ready.
REQ-011 clear_req  input  1  single-cycle pulse requesting a full clear sweep.
REQ-012 writeenable  output  1  write strobe to the 2^AW x DW register file.
REQ-013 wadd  output  AW  register-file write address.
REQ-014 wdata  output  DW  register-file write data.
REQ-015 busy  output  1  high while a clear sweep is in progress.
REQ-016 level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 States SHALL be CLEAR and RUN; reset enters CLEAR with sweep counter 0.
REQ-018 In CLEAR, each edge SHALL register writeenable=1, wadd=counter, wdata=CLR_VAL, then increment the counter; the edge that issues wadd=2^AW-1 SHALL move the state to RUN.
REQ-019 A sweep SHALL take exactly 2^AW consecutive cycles; busy SHALL equal (state==CLEAR).
REQ-020 In RUN with FIFO non-empty, each edge SHALL pop one entry and register writeenable=1, wadd/wdata=entry; with FIFO empty it SHALL register writeenable=0 and hold wadd/wdata.
REQ-021 Latency: a command accepted at edge N into an empty FIFO in RUN SHALL drive writeenable=1 with its address/data from edge N+1 to edge N+2; throughput one write per cycle.
REQ-022 cmd_ready SHALL equal !full && !rst, combinational from occupancy; cmd_ready SHALL NOT depend on cmd_valid.
REQ-023 The FIFO SHALL accept commands in both states; entries accepted during CLEAR SHALL be written, in order, after the sweep.
REQ-024 Simultaneous push and pop SHALL leave level unchanged; at full, no push occurs even when a pop happens on the same edge.
REQ-025 clear_req sampled high in RUN SHALL enter CLEAR at the next edge, counter reset to 0; no FIFO pop occurs on that edge; FIFO contents are retained, not flushed.
REQ-026 clear_req sampled high in CLEAR SHALL be ignored (sweep is not restarted).
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; level SHALL saturate neither below 0 nor above DEPTH.

Reset
REQ-028 rst high on an edge SHALL set writeenable=0, wadd=0, wdata=0, level=0, FIFO pointers=0, state=CLEAR, counter=0, busy=1.
REQ-029 rst asserted mid-sweep or mid-drain SHALL abort it, discard FIFO contents and restart the sweep from address 0 after release.
REQ-030 The first sweep write SHALL be registered on the first edge with rst low.

Structure
REQ-031 AW, DW, NREGS=2^AW and the state enum SHALL live in shared package regfile_pkg.
REQ-032 The FIFO SHALL be a separate sub-module cmd_fifo (synchronous, registered pointers, level output).

Verification
REQ-033 rst high 2 cycles, release -> 16 consecutive cycles writeenable=1, wadd 0..F, wdata 00; busy falls after wadd=F; then writeenable=0.
REQ-034 After sweep, push (0,12),(3,10),(A,17),(B,20),(8,3D) back-to-back -> writes appear in that order one per cycle, first one edge after acceptance; cmd_ready never drops (drain keeps pace).
REQ-035 During sweep push 5 commands -> first 4 accepted, cmd_ready=0 with level=4, 5th stalls until first post-sweep pop; all 5 written in order after wadd=F.
REQ-036 In RUN with 2 entries queued, pulse clear_req -> 16-cycle sweep of 00, then the 2 queued writes; clear_req pulsed mid-sweep -> sweep length unchanged.
REQ-037 Assert rst at sweep address 7 with 3 entries queued -> outputs 0, level 0, new sweep starts at 0 after release, queued entries never written.
REQ-038 Regfile model attached: after REQ-034 sequence, reads of A and 8 return 17 and 3D, unwritten address 5 returns 00.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file write controller.
package regfile_pkg;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned NREGS = 2 ** AW;

    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered pointers and an occupancy count.
module cmd_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH (power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer/level state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Register-file write controller: clear sweep after reset or on request, then
// drains queued write commands one per cycle.
module regfile_wr_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned AW      = regfile_pkg::AW,
    parameter int unsigned DW      = regfile_pkg::DW,
    parameter int unsigned DEPTH   = 4,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    input  logic [AW-1:0]          cmd_addr,
    input  logic [DW-1:0]          cmd_data,
    output logic                   cmd_ready,
    input  logic                   clear_req,
    output logic                   writeenable,
    output logic [AW-1:0]          wadd,
    output logic [DW-1:0]          wdata,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam logic [AW-1:0] LastAddr = {AW{1'b1}};

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   wadd_q, wadd_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic            fifo_full, fifo_empty, fifo_pop;
    logic [AW+DW-1:0] fifo_rd;

    cmd_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid),
        .pop     (fifo_pop),
        .wr_data ({cmd_addr, cmd_data}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign cmd_ready   = !fifo_full && !rst;
    assign busy        = (state_q == StClear);
    assign writeenable = we_q;
    assign wadd        = wadd_q;
    assign wdata       = wdata_q;

    // A clear request in RUN takes priority over draining: no pop on that edge.
    assign fifo_pop = (state_q == StRun) && !clear_req && !fifo_empty;

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wadd_d  = wadd_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StClear: begin
                we_d    = 1'b1;
                wadd_d  = cnt_q;
                wdata_d = CLR_VAL;
                cnt_d   = cnt_q + AW'(1);
                if (cnt_q == LastAddr) state_d = StRun;
            end
            StRun: begin
                if (clear_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else if (!fifo_empty) begin
                    we_d    = 1'b1;
                    wadd_d  = fifo_rd[AW+DW-1:DW];
                    wdata_d = fifo_rd[DW-1:0];
                end
            end
            default: state_d = StClear;
        endcase
    end

    // FSM state, sweep counter and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wadd_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wadd_q  <= wadd_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Scoreboard bench for regfile_wr_ctrl with an attached register-file model.
module tb_regfile_wr_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NREGS = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          cmd_ready;
    logic          clear_req;
    logic          writeenable;
    logic [AW-1:0] wadd;
    logic [DW-1:0] wdata;
    logic          busy;
    logic [2:0]    level;

    always #5 clk = ~clk;

    regfile_wr_ctrl #(
        .AW      (AW),
        .DW      (DW),
        .DEPTH   (DEPTH),
        .CLR_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .clear_req   (clear_req),
        .writeenable (writeenable),
        .wadd        (wadd),
        .wdata       (wdata),
        .busy        (busy),
        .level       (level)
    );

    int checks   = 0;
    int failures = 0;

    logic [AW+DW-1:0] exp_q [$];
    logic [AW+DW-1:0] mon_exp;
    logic [DW-1:0]    rf [NREGS];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register-file model driven by the DUT write port.
    always @(posedge clk) begin
        if (writeenable === 1'b1) rf[wadd] <= wdata;
    end

    // Every observed write must match the head of the expected queue.
    always @(negedge clk) begin
        if (writeenable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexp_we", {31'd0, writeenable}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("wr", {20'd0, wadd, wdata}, {20'd0, mon_exp});
            end
        end
    end

    task automatic push_sweep();
        for (int i = 0; i < NREGS; i++) exp_q.push_back({AW'(i), 8'h00});
    endtask

    task automatic prepend_sweep();
        for (int i = NREGS - 1; i >= 0; i--) exp_q.push_front({AW'(i), 8'h00});
    endtask

    task automatic do_reset(input bit count_sweep);
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        clear_req = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we",    {31'd0, writeenable}, 32'd0);
        check_eq("rst_wadd",  {28'd0, wadd}, 32'd0);
        check_eq("rst_wdata", {24'd0, wdata}, 32'd0);
        check_eq("rst_level", {29'd0, level}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd1);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd0);
        exp_q.delete();
        push_sweep();
        rst = 1'b0;
        if (count_sweep) begin
            n = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                n++;
                if (!busy) break;
            end
            check_eq("sweep_len", n, 32'd16);
            @(posedge clk);
            #1;
            check_eq("we_after_sweep", {31'd0, writeenable}, 32'd0);
        end
    endtask

    // One clock of stimulus; acceptance is judged on the pre-edge cmd_ready.
    task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic clr, output logic acc);
        cmd_valid = v;
        cmd_addr  = a;
        cmd_data  = d;
        clear_req = clr;
        @(negedge clk);
        #1;
        acc = v && cmd_ready;
        if (clr && !busy) prepend_sweep();
        if (acc) exp_q.push_back({a, d});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (!busy && level == 0 && exp_q.size() == 0 && !writeenable) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_eq("idle_timeout", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       acc;
        logic [3:0] a34 [5];
        logic [7:0] d34 [5];
        bit         found;
        a34 = '{4'h0, 4'h3, 4'hA, 4'hB, 4'h8};
        d34 = '{8'h12, 8'h10, 8'h17, 8'h20, 8'h3D};

        // Reset and first sweep
        do_reset(1'b1);

        // Single-command latency
        cyc(1'b1, 4'hC, 8'h55, 1'b0, acc);
        check_eq("lat_acc", {31'd0, acc}, 32'd1);
        check_eq("lat_n", {31'd0, writeenable}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("lat_n1_we", {31'd0, writeenable}, 32'd1);
        check_eq("lat_n1_wr", {20'd0, wadd, wdata}, {20'd0, 4'hC, 8'h55});
        @(posedge clk);
        #1;
        check_eq("lat_n2_we", {31'd0, writeenable}, 32'd0);

        // Back-to-back stream in RUN
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, a34[i], d34[i], 1'b0, acc);
            check_eq("stream_ready", {31'd0, acc}, 32'd1);
        end
        wait_idle();
        check_eq("rf_A", {24'd0, rf[4'hA]}, 32'h17);
        check_eq("rf_8", {24'd0, rf[4'h8]}, 32'h3D);
        check_eq("rf_5", {24'd0, rf[4'h5]}, 32'h00);

        // Commands queued during a sweep
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, AW'(i + 1), 8'hA0 + 8'(i), 1'b0, acc);
            check_eq("sweep_acc", {31'd0, acc}, (i < 4) ? 32'd1 : 32'd0);
            if (i == 3) begin
                check_eq("full_level", {29'd0, level}, 32'd4);
                check_eq("full_ready", {31'd0, cmd_ready}, 32'd0);
            end
        end
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 4'h5, 8'hA4, 1'b0, acc);
            if (acc) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("fifth_accepted", {31'd0, found}, 32'd1);
        check_eq("fifth_level", {29'd0, level}, 32'd3);
        wait_idle();

        // Clear request in RUN with two queued entries, then a mid-sweep request
        cyc(1'b1, 4'h2, 8'hA1, 1'b0, acc);
        cyc(1'b1, 4'h6, 8'hB2, 1'b1, acc);
        check_eq("clr_busy", {31'd0, busy}, 32'd1);
        check_eq("clr_level", {29'd0, level}, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        cyc(1'b0, 4'h0, 8'h00, 1'b1, acc);
        wait_idle();
        check_eq("rf_2", {24'd0, rf[4'h2]}, 32'hA1);
        check_eq("rf_6", {24'd0, rf[4'h6]}, 32'hB2);

        // Reset mid-sweep with entries queued
        do_reset(1'b0);
        cyc(1'b1, 4'h1, 8'hC1, 1'b0, acc);
        cyc(1'b1, 4'h9, 8'hC9, 1'b0, acc);
        cyc(1'b1, 4'hE, 8'hCE, 1'b0, acc);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (writeenable && wadd == 4'h7) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("saw_addr7", {31'd0, found}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("abort_we",    {31'd0, writeenable}, 32'd0);
        check_eq("abort_wadd",  {28'd0, wadd}, 32'd0);
        check_eq("abort_wdata", {24'd0, wdata}, 32'd0);
        check_eq("abort_level", {29'd0, level}, 32'd0);
        check_eq("abort_busy",  {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        push_sweep();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("restart_wr", {19'd0, writeenable, wadd, wdata}, {19'd0, 1'b1, 4'h0, 8'h00});
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        check_eq("rf_1", {24'd0, rf[4'h1]}, 32'h00);
        check_eq("rf_9", {24'd0, rf[4'h9]}, 32'h00);
        check_eq("rf_E", {24'd0, rf[4'hE]}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
